// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: sample width, complex sample type and a
// constant-foldable ceil(log2) used to size counters.
package fft_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } cplx_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dc_delay_line.sv
// Enable-gated shift register of DEPTH words; the output is the word that
// entered DEPTH enabled cycles ago (zero until then).
module dc_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
    logic [WIDTH-1:0] tap_q;
    logic [WIDTH-1:0] tap_d;

    if (gi == 0) begin : g_head
      assign tap_d = din_i;
    end else begin : g_body
      assign tap_d = g_tap[gi-1].tap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tap_q <= '0;
      end else if (clr_i) begin
        tap_q <= '0;
      end else if (en_i) begin
        tap_q <= tap_d;
      end
    end
  end

  assign dout_o = g_tap[DEPTH-1].tap_q;

endmodule

// File: rtl/mdc_delay_commutator.sv
// Radix-2 MDC delay-commutator: upper-lane delay, swap switch every DEPTH
// accepted samples, lower-lane delay. Optional sync clear via DC_SYNC_CLEAR_EN.
module mdc_delay_commutator
  import fft_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DC_SYNC_CLEAR_EN
  input  logic             clr,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] x_re,
  output logic [WIDTH-1:0] x_im,
  output logic [WIDTH-1:0] y_re,
  output logic [WIDTH-1:0] y_im
);

  localparam int CNT_W   = clog2(2 * DEPTH);
  localparam int PRIME_W = clog2(2 * DEPTH + 1);
  localparam int LW      = 2 * WIDTH;
  localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(2 * DEPTH);

  logic               sync_clr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               primed;
  logic               sel;
  logic [LW-1:0]      a_w, b_w, da_w, dl_w, p_w, q_w;
  logic [LW-1:0]      x_q, y_q;
  logic               out_valid_q;

`ifdef DC_SYNC_CLEAR_EN
  assign sync_clr = clr;
`else
  assign sync_clr = 1'b0;
`endif

  assign a_w = {a_re, a_im};
  assign b_w = {b_re, b_im};

  // 2*DEPTH is a power of two, so the natural counter rollover is the wrap.
  assign sel    = cnt_q[CNT_W-1];
  assign cnt_d  = cnt_q + CNT_W'(1);
  assign primed = (prime_q == PRIME_FULL);
  assign prime_d = primed ? prime_q : prime_q + PRIME_W'(1);

  assign p_w = sel ? b_w  : da_w;
  assign q_w = sel ? da_w : b_w;

  dc_delay_line #(
    .WIDTH (LW),
    .DEPTH (DEPTH)
  ) u_upper_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (in_valid),
    .clr_i  (sync_clr),
    .din_i  (a_w),
    .dout_o (da_w)
  );

  dc_delay_line #(
    .WIDTH (LW),
    .DEPTH (DEPTH)
  ) u_lower_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (in_valid),
    .clr_i  (sync_clr),
    .din_i  (q_w),
    .dout_o (dl_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prime_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (sync_clr) begin
      cnt_q       <= '0;
      prime_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // A sample is valid only once both delay lines hold real data.
      out_valid_q <= in_valid & primed;
      if (in_valid) begin
        cnt_q   <= cnt_d;
        prime_q <= prime_d;
        x_q     <= p_w;
        y_q     <= dl_w;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign x_re      = x_q[LW-1:WIDTH];
  assign x_im      = x_q[WIDTH-1:0];
  assign y_re      = y_q[LW-1:WIDTH];
  assign y_im      = y_q[WIDTH-1:0];

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Scoreboard bench for mdc_delay_commutator at DEPTH=2, 4 and 1; the
// clear test is compiled only with DC_SYNC_CLEAR_EN.
module tb_mdc_delay_commutator;
  import fft_pkg::*;

  localparam int W = SAMPLE_W;

  typedef struct packed {
    cplx_t x;
    cplx_t y;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
`ifdef DC_SYNC_CLEAR_EN
  logic clr2;
`endif

  logic         v2, v4, v1;
  logic [W-1:0] a2r, a2i, b2r, b2i, a4r, a4i, b4r, b4i, a1r, a1i, b1r, b1i;
  logic         ov2, ov4, ov1;
  logic [W-1:0] x2r, x2i, y2r, y2i, x4r, x4i, y4r, y4i, x1r, x1i, y1r, y1i;

  exp_t sb2[$];
  exp_t sb4[$];
  exp_t sb1[$];

  int X2_RE[4] = '{2, 3, 106, 107};
  int Y2_RE[4] = '{0, 1, 104, 105};
  int X1_RE[6] = '{1, 103, 3, 105, 5, 107};
  int Y1_RE[6] = '{0, 102, 2, 104, 4, 106};

  int m_ar[64], m_ai[64], m_qr[64], m_qi[64];

  mdc_delay_commutator #(.WIDTH(W), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef DC_SYNC_CLEAR_EN
    .clr(clr2),
`endif
    .in_valid(v2), .a_re(a2r), .a_im(a2i), .b_re(b2r), .b_im(b2i),
    .out_valid(ov2), .x_re(x2r), .x_im(x2i), .y_re(y2r), .y_im(y2i)
  );

  mdc_delay_commutator #(.WIDTH(W), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef DC_SYNC_CLEAR_EN
    .clr(1'b0),
`endif
    .in_valid(v4), .a_re(a4r), .a_im(a4i), .b_re(b4r), .b_im(b4i),
    .out_valid(ov4), .x_re(x4r), .x_im(x4i), .y_re(y4r), .y_im(y4i)
  );

  mdc_delay_commutator #(.WIDTH(W), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef DC_SYNC_CLEAR_EN
    .clr(1'b0),
`endif
    .in_valid(v1), .a_re(a1r), .a_im(a1i), .b_re(b1r), .b_im(b1i),
    .out_valid(ov1), .x_re(x1r), .x_im(x1i), .y_re(y1r), .y_im(y1i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int xr, input int xi, input int yr, input int yi);
    exp_t e;
    e.x.re = W'(xr);
    e.x.im = W'(xi);
    e.y.re = W'(yr);
    e.y.im = W'(yi);
    return e;
  endfunction

  task automatic mon_cmp(input string tag, input exp_t e, input logic [W-1:0] xr,
                         input logic [W-1:0] xi, input logic [W-1:0] yr, input logic [W-1:0] yi);
    $display("%s out x=(%0d,%0d) y=(%0d,%0d)", tag, xr, xi, yr, yi);
    chk({tag, "_x_re"}, 32'(xr), 32'(e.x.re));
    chk({tag, "_x_im"}, 32'(xi), 32'(e.x.im));
    chk({tag, "_y_re"}, 32'(yr), 32'(e.y.re));
    chk({tag, "_y_im"}, 32'(yi), 32'(e.y.im));
  endtask

  always @(negedge clk) begin : mon2
    if (ov2 === 1'b1) begin
      if (sb2.size() == 0) chk("d2_unexpected_valid", 32'(ov2), 32'd0);
      else mon_cmp("d2", sb2.pop_front(), x2r, x2i, y2r, y2i);
    end
  end

  always @(negedge clk) begin : mon4
    if (ov4 === 1'b1) begin
      if (sb4.size() == 0) chk("d4_unexpected_valid", 32'(ov4), 32'd0);
      else mon_cmp("d4", sb4.pop_front(), x4r, x4i, y4r, y4i);
    end
  end

  always @(negedge clk) begin : mon1
    if (ov1 === 1'b1) begin
      if (sb1.size() == 0) chk("d1_unexpected_valid", 32'(ov1), 32'd0);
      else mon_cmp("d1", sb1.pop_front(), x1r, x1i, y1r, y1i);
    end
  end

  task automatic drive2(input logic v, input int k);
    v2 = v; a2r = W'(k); a2i = W'(k + 1000); b2r = W'(100 + k); b2i = W'(1100 + k);
  endtask

  task automatic drive4(input logic v, input int k);
    v4 = v; a4r = W'(k); a4i = W'(k + 1000); b4r = W'(100 + k); b4i = W'(1100 + k);
  endtask

  task automatic drive1(input logic v, input int k);
    v1 = v; a1r = W'(k); a1i = W'(k + 1000); b1r = W'(100 + k); b1i = W'(1100 + k);
  endtask

  task automatic send2(input int k);
    drive2(1'b1, k);
    if (k >= 4 && k <= 7)
      sb2.push_back(mk(X2_RE[k-4], X2_RE[k-4] + 1000, Y2_RE[k-4], Y2_RE[k-4] + 1000));
    step();
  endtask

  task automatic send1(input int k);
    drive1(1'b1, k);
    if (k >= 2 && k <= 7)
      sb1.push_back(mk(X1_RE[k-2], X1_RE[k-2] + 1000, Y1_RE[k-2], Y1_RE[k-2] + 1000));
    step();
  endtask

  // Golden model of the commutator equations for DEPTH=4.
  task automatic send4(input int k);
    int dar, dai, lr, li, pr, pi, qr, qi;
    logic sel;
    drive4(1'b1, k);
    dar = (k >= 4) ? m_ar[k-4] : 0;
    dai = (k >= 4) ? m_ai[k-4] : 0;
    lr  = (k >= 4) ? m_qr[k-4] : 0;
    li  = (k >= 4) ? m_qi[k-4] : 0;
    sel = ((k % 8) >= 4);
    pr = sel ? 100 + k  : dar;
    pi = sel ? 1100 + k : dai;
    qr = sel ? dar : 100 + k;
    qi = sel ? dai : 1100 + k;
    m_ar[k] = k;  m_ai[k] = k + 1000;
    m_qr[k] = qr; m_qi[k] = qi;
    if (k >= 8) sb4.push_back(mk(pr, pi, lr, li));
    step();
  endtask

  task automatic idle_all();
    drive2(1'b0, 999);
    drive4(1'b0, 999);
    drive1(1'b0, 999);
  endtask

  task automatic do_reset();
    idle_all();
    step();
    rst_n = 1'b0;
    step();
    chk("rst_ov2", 32'(ov2), 32'd0);
    chk("rst_x2", {x2r, x2i}, 32'd0);
    chk("rst_y2", {y2r, y2i}, 32'd0);
    chk("rst_ov4", 32'(ov4), 32'd0);
    chk("rst_ov1", 32'(ov1), 32'd0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    idle_all();
    step();
    step();
    chk({name, "_sb2_left"}, 32'(sb2.size()), 32'd0);
    chk({name, "_sb4_left"}, 32'(sb4.size()), 32'd0);
    chk({name, "_sb1_left"}, 32'(sb1.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef DC_SYNC_CLEAR_EN
    clr2 = 1'b0;
`endif
    idle_all();
    do_reset();

    // Continuous stream, DEPTH=2
    for (int k = 0; k < 8; k++) send2(k);
    drain("t1");

    // Three idle cycles between k=5 and k=6
    do_reset();
    for (int k = 0; k < 6; k++) send2(k);
    drive2(1'b0, 555);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_ov", 32'(ov2), 32'd0);
      chk("gap_x_re", 32'(x2r), 32'd3);
      chk("gap_y_re", 32'(y2r), 32'd1);
      chk("gap_x_im", 32'(x2i), 32'd1003);
    end
    for (int k = 6; k < 8; k++) send2(k);
    drain("t2");

    // Reset mid-frame, then restart
    do_reset();
    for (int k = 0; k < 6; k++) send2(k);
    do_reset();
    for (int k = 0; k < 8; k++) send2(k);
    drain("t3");

    // Counter wrap, DEPTH=4, 40 samples
    do_reset();
    for (int k = 0; k < 40; k++) send4(k);
    drain("t4");

    // DEPTH=1 alternating switch
    do_reset();
    for (int k = 0; k < 8; k++) send1(k);
    drain("t5");

`ifdef DC_SYNC_CLEAR_EN
    // Sync clear wins over in_valid at k=6
    do_reset();
    for (int k = 0; k < 6; k++) send2(k);
    drive2(1'b1, 6);
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    chk("clr_ov", 32'(ov2), 32'd0);
    chk("clr_x", {x2r, x2i}, 32'd0);
    chk("clr_y", {y2r, y2i}, 32'd0);
    for (int k = 0; k < 8; k++) send2(k);
    drain("t6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
